// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and mid-bit sample offsets.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_e;

  // Majority samples sit at OVERSAMPLE/2 + offset (ticks 7, 8, 9 at 16x).
  localparam int MAJ_OFS_A = -1;
  localparam int MAJ_OFS_B = 0;
  localparam int MAJ_OFS_C = 1;

  function automatic parity_e decode_parity(input logic [1:0] code);
    case (code)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic [3:0] clamp_bits(input logic [3:0] bits, input int max_bits);
    if (int'(bits) < 5)             return 4'd5;
    else if (int'(bits) > max_bits) return 4'(max_bits);
    else                            return bits;
  endfunction

endpackage

// File: rtl/CDCSynchron.sv
// Two-flop synchroniser for a single asynchronous level.
module CDCSynchron #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic sourceClk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: down-counter reloading from div, tick on zero, restartable.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 sourceClk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset)                        count <= '0;
    else if (restart || count == '0)   count <= div;
    else                               count <= count - 1'b1;
  end

  // A restart cycle is phase 0: the first tick follows div+1 clocks later.
  assign tick = (count == '0) && !restart;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable 16x-oversampling UART receiver with error flags, break detect and valid/ready output.
//   state      | meaning
//   IDLE       | line idle, waiting for a falling edge
//   START      | qualifying start bit by mid-bit majority
//   DATA       | sampling data bits LSB first
//   PARITY     | sampling the parity bit
//   STOP       | sampling one or two stop bits; frame ends at last stop mid-point
//   BREAK_WAIT | all-zero frame seen; waiting for one full high bit time
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int DIV_WIDTH     = 16,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                     sourceClk,
  input  logic                     reset,
  input  logic                     rx_in,
  input  logic [DIV_WIDTH-1:0]     baud_div,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun_err,
  output logic                     break_det
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] TICK_A   = SW'(OVERSAMPLE / 2 + MAJ_OFS_A);
  localparam logic [SW-1:0] TICK_B   = SW'(OVERSAMPLE / 2 + MAJ_OFS_B);
  localparam logic [SW-1:0] TICK_C   = SW'(OVERSAMPLE / 2 + MAJ_OFS_C);
  localparam logic [SW-1:0] TICK_END = SW'(OVERSAMPLE - 1);

  rx_state_e                state, state_d;
  logic                     rx_s, rx_prev, fall, tick, restart;
  logic [DIV_WIDTH-1:0]     div_q, div_d, tick_div;
  logic [SW-1:0]            scnt, scnt_d;
  logic [3:0]               bitcnt, bitcnt_d, nbits, nbits_d;
  parity_e                  par_mode, par_mode_d;
  logic                     stop2, stop2_d, stop_idx, stop_idx_d;
  logic                     s_a, s_a_d, s_b, s_b_d, maj;
  logic                     at_a, at_b, at_c, at_end;
  logic [MAX_DATA_BITS-1:0] shreg, shreg_d;
  logic                     par_bit, par_bit_d, ferr, ferr_d, ones, ones_d;
  logic                     done_d, done_q, brk_d, par_calc;

  CDCSynchron #(.RESET_VAL(1'b1)) u_sync (
    .sourceClk (sourceClk),
    .reset     (reset),
    .d         (rx_in),
    .q         (rx_s)
  );

  // Live divisor while idle so the restart at the start edge uses the new value.
  assign tick_div = (state == IDLE) ? baud_div : div_q;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .sourceClk (sourceClk),
    .reset     (reset),
    .restart   (restart),
    .div       (tick_div),
    .tick      (tick)
  );

  assign fall   = rx_prev & ~rx_s;
  assign at_a   = tick && (scnt == TICK_A);
  assign at_b   = tick && (scnt == TICK_B);
  assign at_c   = tick && (scnt == TICK_C);
  assign at_end = tick && (scnt == TICK_END);
  assign maj    = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);

  always_comb begin
    state_d    = state;
    scnt_d     = tick ? scnt + 1'b1 : scnt;
    bitcnt_d   = bitcnt;
    nbits_d    = nbits;
    par_mode_d = par_mode;
    stop2_d    = stop2;
    stop_idx_d = stop_idx;
    div_d      = div_q;
    s_a_d      = at_a ? rx_s : s_a;
    s_b_d      = at_b ? rx_s : s_b;
    shreg_d    = shreg;
    par_bit_d  = par_bit;
    ferr_d     = ferr;
    ones_d     = ones;
    restart    = 1'b0;
    done_d     = 1'b0;
    brk_d      = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          restart    = 1'b1;
          scnt_d     = '0;
          bitcnt_d   = '0;
          stop_idx_d = 1'b0;
          shreg_d    = '0;
          par_bit_d  = 1'b0;
          ferr_d     = 1'b0;
          ones_d     = 1'b0;
          nbits_d    = clamp_bits(cfg_data_bits, MAX_DATA_BITS);
          par_mode_d = decode_parity(cfg_parity);
          stop2_d    = cfg_stop2;
          div_d      = baud_div;
        end
      end
      START: begin
        if (at_c && maj)  state_d = IDLE;
        else if (at_end)  state_d = DATA;
      end
      DATA: begin
        if (at_c) begin
          shreg_d = shreg | (MAX_DATA_BITS'(maj) << bitcnt);
          ones_d  = ones | maj;
        end
        if (at_end) begin
          if (bitcnt == nbits - 4'd1) state_d = (par_mode == PAR_NONE) ? STOP : PARITY;
          else                        bitcnt_d = bitcnt + 4'd1;
        end
      end
      PARITY: begin
        if (at_c) begin
          par_bit_d = maj;
          ones_d    = ones | maj;
        end
        if (at_end) state_d = STOP;
      end
      STOP: begin
        if (at_c) begin
          ferr_d = ferr | ~maj;
          if (!stop2 || stop_idx) begin
            if (ones | maj) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = BREAK_WAIT;
              brk_d   = 1'b1;
              scnt_d  = '0;
            end
          end
        end else if (at_end) begin
          stop_idx_d = 1'b1;
        end
      end
      BREAK_WAIT: begin
        // scnt counts consecutive high ticks; any low sample restarts the bit time.
        if (tick) begin
          if (!rx_s)                  scnt_d  = '0;
          else if (scnt == TICK_END)  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rx_prev  <= 1'b1;
      scnt     <= '0;
      bitcnt   <= '0;
      nbits    <= 4'd8;
      par_mode <= PAR_NONE;
      stop2    <= 1'b0;
      stop_idx <= 1'b0;
      div_q    <= '0;
      s_a      <= 1'b1;
      s_b      <= 1'b1;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr     <= 1'b0;
      ones     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      rx_prev  <= rx_s;
      scnt     <= scnt_d;
      bitcnt   <= bitcnt_d;
      nbits    <= nbits_d;
      par_mode <= par_mode_d;
      stop2    <= stop2_d;
      stop_idx <= stop_idx_d;
      div_q    <= div_d;
      s_a      <= s_a_d;
      s_b      <= s_b_d;
      shreg    <= shreg_d;
      par_bit  <= par_bit_d;
      ferr     <= ferr_d;
      ones     <= ones_d;
      done_q   <= done_d;
    end
  end

  assign par_calc = (par_mode != PAR_NONE) &&
                    ((^shreg ^ par_bit) != (par_mode == PAR_ODD));

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      break_det <= brk_d;
      if (done_q) begin
        // A same-cycle handshake frees the slot, so the new word is taken without overrun.
        if (!rx_valid || rx_ready) begin
          rx_data     <= shreg;
          parity_err  <= par_calc;
          frame_err   <= ferr;
          rx_valid    <= 1'b1;
          overrun_err <= 1'b0;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid    <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised and directed frames against a bit-level frame model of the receiver.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int MDB = 9;
  localparam int DW  = 16;
  localparam int OS  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rx_in = 1'b1;
  logic [DW-1:0]  baud_div = 16'd3;
  logic [3:0]     cfg_data_bits = 4'd8;
  logic [1:0]     cfg_parity = 2'd0;
  logic           cfg_stop2 = 1'b0;
  logic           rx_ready = 1'b0;
  logic [MDB-1:0] rx_data;
  logic           rx_valid, parity_err, frame_err, overrun_err, break_det;

  int n_cmp = 0;
  int n_bad = 0;
  int brk_cnt = 0;
  int f_div, f_nb, f_par;
  bit f_st2;

  always #5 clk = ~clk;

  uart_rx_cfg #(.MAX_DATA_BITS(MDB), .DIV_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .sourceClk     (clk),
    .reset         (rst_n),
    .rx_in         (rx_in),
    .baud_div      (baud_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err),
    .break_det     (break_det)
  );

  always @(negedge clk) if (break_det) brk_cnt = brk_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int dv, input int nb, input int par, input bit st2);
    f_div = dv; f_nb = nb; f_par = par; f_st2 = st2;
  endtask

  // Drives one frame and predicts its outcome from the bits actually put on the line.
  task automatic send_frame(input logic [8:0] d, input logic flip, input logic [1:0] bad_stop,
                            input bit scramble, output logic exp_pe, output logic exp_fe,
                            output logic exp_brk);
    int   bc, ones;
    logic p;
    bc = (f_div + 1) * OS;
    baud_div = DW'(f_div); cfg_data_bits = 4'(f_nb); cfg_parity = 2'(f_par); cfg_stop2 = f_st2;
    rx_in = 1'b1;
    repeat (2 * bc) @(negedge clk);
    rx_in = 1'b0;
    repeat (bc) @(negedge clk);
    if (scramble) begin
      baud_div      = DW'($urandom_range(0, 7));
      cfg_data_bits = 4'($urandom_range(5, 9));
      cfg_parity    = 2'($urandom_range(0, 3));
      cfg_stop2     = 1'($urandom_range(0, 1));
    end
    ones = 0;
    for (int i = 0; i < f_nb; i++) begin
      rx_in = d[i];
      if (d[i]) ones++;
      repeat (bc) @(negedge clk);
    end
    exp_pe = 1'b0;
    if (f_par == 1 || f_par == 2) begin
      p = ((ones % 2) == 1) ^ (f_par == 2) ^ flip;
      rx_in = p;
      repeat (bc) @(negedge clk);
      if (p) ones++;
      exp_pe = ((ones % 2) == 1) != (f_par == 2);
    end
    rx_in = ~bad_stop[0];
    repeat (bc) @(negedge clk);
    exp_fe = bad_stop[0];
    if (!bad_stop[0]) ones++;
    if (f_st2) begin
      rx_in = ~bad_stop[1];
      repeat (bc) @(negedge clk);
      exp_fe = exp_fe | bad_stop[1];
      if (!bad_stop[1]) ones++;
    end
    rx_in = 1'b1;
    exp_brk = (ones == 0);
  endtask

  task automatic run_frame(input string tag, input logic [8:0] d, input logic flip,
                           input logic [1:0] bad_stop, input bit scramble);
    logic       pe, fe, brk;
    logic [8:0] mask;
    int         b0, bc, t;
    b0   = brk_cnt;
    bc   = (f_div + 1) * OS;
    mask = 9'((1 << f_nb) - 1);
    send_frame(d, flip, bad_stop, scramble, pe, fe, brk);
    if (brk) begin
      repeat (bc) @(negedge clk);
      chk({tag, "_brk_pulses"}, brk_cnt - b0, 1);
      chk({tag, "_brk_valid"}, rx_valid, 0);
    end else begin
      t = 0;
      while (!rx_valid && t < 4 * bc) begin
        @(negedge clk);
        t++;
      end
      chk({tag, "_valid"}, rx_valid, 1);
      chk({tag, "_data"}, rx_data, d & mask);
      chk({tag, "_perr"}, parity_err, pe);
      chk({tag, "_ferr"}, frame_err, fe);
      chk({tag, "_ovr"}, overrun_err, 0);
      chk({tag, "_nobrk"}, brk_cnt - b0, 0);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk({tag, "_cleared"}, rx_valid, 0);
    end
  endtask

  initial begin
    logic       pe, fe, brk;
    logic [8:0] d;
    logic [1:0] bs;
    int         b0;
    repeat (4) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun_err, 0);
    chk("rst_brk", break_det, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    set_cfg(3, 8, 0, 0);
    run_frame("a5_8n1", 9'h0A5, 0, 2'b00, 0);

    set_cfg(3, 7, 1, 1);
    run_frame("41_7e2", 9'h041, 1, 2'b00, 0);

    set_cfg(3, 8, 0, 0);
    b0 = brk_cnt;
    rx_in = 1'b0;
    repeat (3 * 4) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * 64) @(negedge clk);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_idle", 32'(dut.state), 32'(IDLE));
    chk("glitch_nobrk", brk_cnt - b0, 0);
    run_frame("3c_after_glitch", 9'h03C, 0, 2'b00, 0);

    set_cfg(3, 9, 0, 0);
    run_frame("1ff_9n1_fe", 9'h1FF, 0, 2'b01, 0);
    run_frame("break", 9'h000, 0, 2'b11, 0);
    run_frame("after_break", 9'h12D, 0, 2'b00, 0);

    set_cfg(3, 8, 0, 0);
    send_frame(9'h011, 0, 2'b00, 0, pe, fe, brk);
    send_frame(9'h022, 0, 2'b00, 0, pe, fe, brk);
    repeat (4) @(negedge clk);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 9'h011);
    chk("ovr_flag", overrun_err, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("ovr_clr_valid", rx_valid, 0);
    chk("ovr_clr_flag", overrun_err, 0);

    rx_in = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = (i % 2 == 0);
      repeat (64) @(negedge clk);
    end
    rx_in = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_valid", rx_valid, 0);
    rst_n = 1'b1;
    repeat (3 * 64) @(negedge clk);
    chk("midrst_discard", rx_valid, 0);
    run_frame("66_after_rst", 9'h066, 0, 2'b00, 0);

    for (int n = 0; n < 16; n++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(5, 9), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
      d  = 9'($urandom);
      bs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 7) == 0) begin
        d  = 9'h000;
        bs = 2'b11;
      end
      run_frame($sformatf("rnd%0d", n), d, ($urandom_range(0, 3) == 0) && (d != 0),
                bs, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
